// File: rtl/noc_switch_alloc.sv
// noc_switch_alloc: wormhole switch allocator, round-robin per output, packet-long output locks.
// Define SWITCH_ALLOC_TIMEOUT_EN to force-release outputs whose owner stays idle for TIMEOUT cycles.
module noc_switch_alloc #(
  parameter int NPORTS = 5
`ifdef SWITCH_ALLOC_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NPORTS-1:0]   req_valid_i,
  input  logic [3*NPORTS-1:0] req_port_addr_i,
  input  logic [NPORTS-1:0]   req_tail_i,
  input  logic [NPORTS-1:0]   out_ready_i,
  output logic [NPORTS-1:0]   in_pop_o,
  output logic [NPORTS-1:0]   out_valid_o,
  output logic [3*NPORTS-1:0] xbar_sel_o,
  output logic                addr_err_o
`ifdef SWITCH_ALLOC_TIMEOUT_EN
  ,
  output logic [NPORTS-1:0]   timeout_o
`endif
);
  logic [NPORTS-1:0] r_locked, w_locked_nxt;
  logic [2:0]        r_owner [NPORTS];
  logic [2:0]        w_owner_nxt [NPORTS];
  logic [2:0]        r_ptr [NPORTS];
  logic [2:0]        w_ptr_nxt [NPORTS];
  logic              r_err, w_err_nxt;
  logic [NPORTS-1:0] w_in_locked, w_xfer, w_bad, w_force;
  logic [NPORTS-1:0] w_cand [NPORTS];
  logic [3:0]        w_pick [NPORTS];

  function automatic logic [2:0] inc(input logic [2:0] p);
    return (p == 3'(NPORTS-1)) ? 3'd0 : p + 3'd1;
  endfunction

  // returns {found, index} of the first set bit of c scanning from p upward with wrap
  function automatic logic [3:0] pick(input logic [NPORTS-1:0] c, input logic [2:0] p);
    logic [2:0] j;
    logic [3:0] r;
    j = p;
    r = 4'd0;
    for (int k = 0; k < NPORTS; k++) begin
      if (!r[3] && c[j]) r = {1'b1, j};
      j = inc(j);
    end
    return r;
  endfunction

  always_comb begin
    w_in_locked = '0;
    w_bad = '0;
    for (int o = 0; o < NPORTS; o++)
      if (r_locked[o]) w_in_locked[r_owner[o]] = 1'b1;
    for (int o = 0; o < NPORTS; o++) begin
      w_cand[o] = '0;
      for (int i = 0; i < NPORTS; i++)
        w_cand[o][i] = req_valid_i[i] & ~w_in_locked[i] & (req_port_addr_i[3*i +: 3] == 3'(o));
      w_pick[o] = pick(w_cand[o], r_ptr[o]);
    end
    for (int i = 0; i < NPORTS; i++)
      w_bad[i] = req_valid_i[i] & ~w_in_locked[i] & (req_port_addr_i[3*i +: 3] >= 3'(NPORTS));
  end

  always_comb begin
    in_pop_o = '0;
    out_valid_o = '0;
    xbar_sel_o = '1;
    w_xfer = '0;
    for (int o = 0; o < NPORTS; o++)
      if (r_locked[o]) begin
        out_valid_o[o] = req_valid_i[r_owner[o]];
        w_xfer[o] = req_valid_i[r_owner[o]] & out_ready_i[o];
        in_pop_o[r_owner[o]] = w_xfer[o];
        xbar_sel_o[3*o +: 3] = r_owner[o];
      end
    addr_err_o = r_err;
  end

  always_comb begin
    w_err_nxt = r_err | (|w_bad);
    for (int o = 0; o < NPORTS; o++) begin
      w_locked_nxt[o] = r_locked[o];
      w_owner_nxt[o] = r_owner[o];
      w_ptr_nxt[o] = r_ptr[o];
      if (r_locked[o]) begin
        if ((w_xfer[o] & req_tail_i[r_owner[o]]) | w_force[o]) begin
          w_locked_nxt[o] = 1'b0;
          w_ptr_nxt[o] = inc(r_owner[o]);
        end
      end else if (w_pick[o][3]) begin
        w_locked_nxt[o] = 1'b1;
        w_owner_nxt[o] = w_pick[o][2:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_locked <= '0;
      r_err <= 1'b0;
      for (int o = 0; o < NPORTS; o++) begin
        r_owner[o] <= '0;
        r_ptr[o] <= '0;
      end
    end else begin
      r_locked <= w_locked_nxt;
      r_err <= w_err_nxt;
      r_owner <= w_owner_nxt;
      r_ptr <= w_ptr_nxt;
    end

`ifdef SWITCH_ALLOC_TIMEOUT_EN
  logic [6:0] r_cnt [NPORTS];

  always_comb
    for (int o = 0; o < NPORTS; o++)
      w_force[o] = r_locked[o] & (r_cnt[o] == 7'(TIMEOUT));

  assign timeout_o = w_force;

  // counts consecutive idle cycles of the owner; any valid flit or a release clears it
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int o = 0; o < NPORTS; o++) r_cnt[o] <= '0;
    end else begin
      for (int o = 0; o < NPORTS; o++)
        r_cnt[o] <= (r_locked[o] & w_locked_nxt[o] & ~req_valid_i[r_owner[o]]) ? r_cnt[o] + 7'd1 : 7'd0;
    end
`else
  assign w_force = '0;
`endif
endmodule

// File: tb/tb_noc_switch_alloc.sv
// tb_noc_switch_alloc: randomized packet traffic against a queue-based reference model, scoreboard-checked every cycle.
module tb_noc_switch_alloc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  req_valid = '0, req_tail = '0, out_ready = '0;
  logic [14:0] req_addr = '0;
  logic [4:0]  in_pop, out_valid;
  logic [14:0] xbar_sel;
  logic        addr_err;

  always #5 clk = ~clk;

  noc_switch_alloc dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_port_addr_i(req_addr),
    .req_tail_i(req_tail), .out_ready_i(out_ready), .in_pop_o(in_pop), .out_valid_o(out_valid),
    .xbar_sel_o(xbar_sel), .addr_err_o(addr_err)
  );

  typedef struct {
    logic [4:0]  pop;
    logic [4:0]  val;
    logic [14:0] sel;
    logic        err;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int m_own[5];
  int m_ptr[5];
  bit m_err;
  int pk_rem[5];
  int pk_age[5];
  logic [2:0] pk_addr[5];

  task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < 5; o++) begin
      m_own[o] = -1;
      m_ptr[o] = 0;
    end
    m_err = 0;
  endtask

  // drives one cycle of traffic, predicts this cycle's outputs, then advances the model
  task automatic step(input bit rnd);
    logic [4:0] v, t, r;
    exp_t e;
    bit lk[5];
    int w, c;
    for (int i = 0; i < 5; i++) begin
      if (rnd && pk_rem[i] == 0 && $urandom_range(0, 3) == 0) begin
        pk_rem[i] = $urandom_range(1, 4);
        pk_addr[i] = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        pk_age[i] = 0;
      end
      v[i] = pk_rem[i] > 0 && (!rnd || $urandom_range(0, 9) < 8);
      t[i] = pk_rem[i] == 1;
      r[i] = !rnd || $urandom_range(0, 4) != 0;
      req_addr[3*i +: 3] = pk_addr[i];
    end
    req_valid = v;
    req_tail = t;
    out_ready = r;
    e.pop = '0;
    e.val = '0;
    e.sel = '1;
    e.err = m_err;
    for (int i = 0; i < 5; i++) lk[i] = 0;
    for (int o = 0; o < 5; o++) if (m_own[o] >= 0) lk[m_own[o]] = 1;
    for (int o = 0; o < 5; o++)
      if (m_own[o] >= 0) begin
        w = m_own[o];
        e.val[o] = v[w];
        e.pop[w] = v[w] & r[o];
        e.sel[3*o +: 3] = 3'(w);
      end
    q.push_back(e);
    for (int o = 0; o < 5; o++) begin
      if (m_own[o] >= 0) begin
        if (e.pop[m_own[o]] && t[m_own[o]]) begin
          m_ptr[o] = (m_own[o] + 1) % 5;
          m_own[o] = -1;
        end
      end else begin
        for (int k = 0; k < 5; k++) begin
          c = (m_ptr[o] + k) % 5;
          if (m_own[o] < 0 && v[c] && int'(pk_addr[c]) == o && !lk[c]) m_own[o] = c;
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (v[i] && !lk[i] && pk_addr[i] >= 3'd5) m_err = 1;
      if (e.pop[i]) pk_rem[i]--;
      if (pk_addr[i] >= 3'd5 && pk_rem[i] > 0) begin
        pk_age[i]++;
        if (pk_age[i] > 8) pk_rem[i] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit busy();
    for (int i = 0; i < 5; i++) if (pk_rem[i] > 0) return 1;
    return 0;
  endfunction

  task automatic run_until_done(input int limit);
    int n;
    n = 0;
    while (busy() && n < limit) begin
      step(0);
      n++;
    end
    if (busy()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: packets still pending after %0d cycles", limit);
      for (int i = 0; i < 5; i++) pk_rem[i] = 0;
    end
    step(0);
    step(0);
  endtask

  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("in_pop", 15'(in_pop), 15'(e.pop));
      chk("out_valid", 15'(out_valid), 15'(e.val));
      chk("xbar_sel", xbar_sel, e.sel);
      chk("addr_err", 15'(addr_err), 15'(e.err));
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < 5; i++) begin
      pk_rem[i] = 0;
      pk_age[i] = 0;
      pk_addr[i] = 3'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pop", 15'(in_pop), 15'd0);
    chk("rst_valid", 15'(out_valid), 15'd0);
    chk("rst_sel", xbar_sel, 15'h7fff);
    chk("rst_err", 15'(addr_err), 15'd0);
    rst_n = 1'b1;
    pk_rem[0] = 3;
    pk_addr[0] = 3'd2;
    run_until_done(20);
    pk_rem[1] = 1;
    pk_addr[1] = 3'd4;
    pk_rem[3] = 1;
    pk_addr[3] = 3'd4;
    run_until_done(20);
    for (int r = 0; r < 2; r++) begin
      foreach (pk_rem[i]) if (i == 0 || i == 1 || i == 4) begin
        pk_rem[i] = 1;
        pk_addr[i] = 3'd2;
      end
      run_until_done(30);
    end
    pk_rem[3] = 1;
    pk_addr[3] = 3'd6;
    run_until_done(20);
    repeat (3000) step(1);
    run_until_done(300);
    pk_rem[2] = 3;
    pk_addr[2] = 3'd0;
    step(0);
    step(0);
    #1;
    chk("pop_before_rst", 15'(in_pop), 15'h04);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pop", 15'(in_pop), 15'd0);
    chk("async_rst_sel", xbar_sel, 15'h7fff);
    chk("async_rst_valid", 15'(out_valid), 15'd0);
    chk("async_rst_err", 15'(addr_err), 15'd0);
    repeat (3) @(posedge clk);
    chk("queue_empty", 15'(q.size()), 15'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
